puf_race_reader: RTL
====================

# puf_race_reader

Sequential read-out controller on the output end of the arbiter-PUF delay chain. It accepts a challenge, drives the per-stage `sel` lines, launches a rising edge into both race paths, and arbitrates which chain output (`race_top` / `race_bot`) rises first. It repeats the race for majority voting, then returns one response bit plus a confidence count over a valid/ready handshake. It sits between the chain of single-round PUF stages and the CRP collection logic.

## Interface
- `N_STAGES`, default 8: challenge width; one `sel` bit per chain stage.
- `SETTLE_CYCLES`, default 16: maximum cycles allowed for a race, and for chain discharge.
- `N_VOTES`, default 7: races per challenge; must be odd, range 1..255.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `chal_valid`  in  1  challenge offered.
- `chal_ready`  out  1  controller can accept a challenge.
- `challenge`  in  N_STAGES  challenge bits.
- `sel`  out  N_STAGES  registered stage selects, driven to the chain.
- `launch`  out  1  common rising edge into both chain inputs.
- `race_top`  in  1  chain top-path output.
- `race_bot`  in  1  chain bottom-path output.
- `resp_valid`  out  1  response available.
- `resp_ready`  in  1  consumer accepts the response.
- `resp_bit`  out  1  majority response.
- `resp_conf`  out  8  number of votes equal to 1.
- `timeout_err`  out  1  sticky; a race or discharge exceeded `SETTLE_CYCLES`. Cleared on challenge acceptance.

## Operation
- Reset values: `chal_ready=1`, `sel=0`, `launch=0`, `resp_valid=0`, `resp_bit=0`, `resp_conf=0`, `timeout_err=0`, state IDLE, all counters 0.
- **IDLE**:
  - `chal_ready=1`.
  - On `chal_valid & chal_ready`: latch `challenge` into `sel`, clear the vote count, ones count and `timeout_err`, then go to DISCHARGE.
- **DISCHARGE**:
  - `launch=0`.
  - Wait until `race_top==0 & race_bot==0`, then go to LAUNCH.
  - If the wait reaches `SETTLE_CYCLES`, set `timeout_err` and go to LAUNCH anyway.
- **LAUNCH**: `launch=1` for this and all following race cycles; go to RACE.
- **RACE**: sample both race inputs each cycle. On the first cycle either input is 1:
  - only `race_top` is 1 → vote 1;
  - only `race_bot` is 1 → vote 0;
  - both are 1 (tie) → vote 0.
  - If neither input rises within `SETTLE_CYCLES` cycles → vote 0 and set `timeout_err`.
  - After the vote, go to ACCUM.
- **ACCUM**:
  - `launch=0`; add the vote to the ones count; increment the vote count.
  - If the vote count equals `N_VOTES`, go to DONE; otherwise go to DISCHARGE.
- **DONE**:
  - `resp_valid=1`; `resp_bit = (ones > N_VOTES/2)`; `resp_conf = ones`.
  - Hold these until `resp_valid & resp_ready`, then return to IDLE.
- `sel` holds its value from acceptance until the next acceptance; it never changes mid-race.
- `chal_valid` outside IDLE is ignored and does not disturb the current challenge.
- Assertion of `rst_n` at any point aborts the current challenge, with all outputs at their reset values immediately.

## Timing
- Acceptance edge at cycle 0:
  - `sel` is valid at cycle 1.
  - `launch` rises at cycle 2, provided the chain is already discharged.
- Vote latency: one cycle after the first cycle a race input is seen high.
- Per-race cycle cost is 3 + r + d, where r is race cycles (1..`SETTLE_CYCLES`) and d is discharge wait cycles (0..`SETTLE_CYCLES`).
- Fast path (`N_VOTES=1`, race seen on its first cycle): `resp_valid` rises 5 cycles after the acceptance edge.
- `resp_ready` may already be high when `resp_valid` rises; the response transfers on that same edge and `chal_ready` is 1 on the next cycle.
- `race_top` and `race_bot` are treated as synchronous inputs; the chain-side synchronizer is outside this block.

## Configuration
- `PUF_MAJORITY_VOTE_EN` defined: `N_VOTES` races per challenge with the majority rule as above.
- Not defined:
  - `N_VOTES` is ignored and exactly one race runs per challenge.
  - `resp_bit` is the single vote; `resp_conf` is 0 or 1.
  - The vote counter is not synthesized.

## Test plan
- Reset during RACE (`N_VOTES=7`, after 3 votes): `launch`, `resp_valid` and `sel` are 0 immediately; after reset release, `chal_ready=1`.
- `challenge=8'hA5`, `race_top` rises 3 cycles after `launch` in every race, `race_bot` never rises: `sel=8'hA5`, `resp_bit=1`, `resp_conf=7`, `timeout_err=0`.
- Alternating winners top/bot/top/bot/top/bot/bot: `resp_bit=0`, `resp_conf=3`.
- Simultaneous rise in every race: `resp_bit=0`, `resp_conf=0`.
- No race input ever rises (`SETTLE_CYCLES=16`): each race ends after 16 cycles, `timeout_err=1`, `resp_bit=0`; the next acceptance clears `timeout_err`.
- `resp_ready` held low for 10 cycles in DONE: `resp_valid`, `resp_bit` and `resp_conf` stay stable, a new `chal_valid` is ignored, and `chal_ready` rises the cycle after the handshake.

Source files
------------

// File: rtl/puf_race_reader.sv
// Arbiter-PUF read-out controller: discharge, launch, arbitrate, vote, respond.
// Define PUF_MAJORITY_VOTE_EN for N_VOTES-race majority voting; otherwise one race per challenge.
module puf_race_reader #(
  parameter int N_STAGES      = 8,
  parameter int SETTLE_CYCLES = 16,
  parameter int N_VOTES       = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                chal_valid,
  output logic                chal_ready,
  input  logic [N_STAGES-1:0] challenge,
  output logic [N_STAGES-1:0] sel,
  output logic                launch,
  input  logic                race_top,
  input  logic                race_bot,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic                resp_bit,
  output logic [7:0]          resp_conf,
  output logic                timeout_err
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] DIS_LAST  = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] RACE_LAST = CW'(SETTLE_CYCLES - 1);

  if ((N_VOTES % 2) == 0 || N_VOTES < 1 || N_VOTES > 255) begin : g_bad_votes
    $error("N_VOTES must be odd and within 1..255");
  end

  typedef enum logic [2:0] {IDLE, DISCHARGE, LAUNCH, RACE, ACCUM, DONE} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic                  vote, vote_nxt;
  logic [7:0]            ones, ones_nxt;
  logic                  to_nxt;
  logic [N_STAGES-1:0]   sel_nxt;
  logic                  last_vote;

`ifdef PUF_MAJORITY_VOTE_EN
  localparam logic [7:0] HALF     = 8'(N_VOTES / 2);
  localparam logic [7:0] VOTE_MAX = 8'(N_VOTES);
  logic [7:0] nvote, nvote_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) nvote <= '0;
    else        nvote <= nvote_nxt;
  end

  always_comb begin
    nvote_nxt = nvote;
    if (state == IDLE && chal_valid)
      nvote_nxt = '0;
    else if (state == ACCUM)
      nvote_nxt = nvote + 8'd1;
  end

  assign last_vote = (nvote + 8'd1) == VOTE_MAX;
`else
  localparam logic [7:0] HALF = 8'd0;
  assign last_vote = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      vote        <= 1'b0;
      ones        <= '0;
      timeout_err <= 1'b0;
      sel         <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      vote        <= vote_nxt;
      ones        <= ones_nxt;
      timeout_err <= to_nxt;
      sel         <= sel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    vote_nxt  = vote;
    ones_nxt  = ones;
    to_nxt    = timeout_err;
    sel_nxt   = sel;
    case (state)
      IDLE: if (chal_valid) begin
        sel_nxt   = challenge;
        ones_nxt  = '0;
        to_nxt    = 1'b0;
        cnt_nxt   = '0;
        state_nxt = DISCHARGE;
      end
      // Chain must be fully low before a fair race; give up after the settle window.
      DISCHARGE: begin
        if (!race_top && !race_bot) begin
          cnt_nxt   = '0;
          state_nxt = LAUNCH;
        end else if (cnt == DIS_LAST) begin
          to_nxt    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = LAUNCH;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      LAUNCH: begin
        cnt_nxt   = '0;
        state_nxt = RACE;
      end
      // Tie resolves to 0 so only a clean top-path win counts as a 1.
      RACE: begin
        if (race_top || race_bot) begin
          vote_nxt  = race_top & ~race_bot;
          cnt_nxt   = '0;
          state_nxt = ACCUM;
        end else if (cnt == RACE_LAST) begin
          vote_nxt  = 1'b0;
          to_nxt    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ACCUM;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ACCUM: begin
        ones_nxt  = ones + {7'd0, vote};
        state_nxt = last_vote ? DONE : DISCHARGE;
      end
      DONE: if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign chal_ready = (state == IDLE);
  assign launch     = (state == LAUNCH) || (state == RACE);
  assign resp_valid = (state == DONE);
  assign resp_bit   = (state == DONE) && (ones > HALF);
  assign resp_conf  = (state == DONE) ? ones : 8'd0;

endmodule
